// File: rtl/simd_issue_sequencer.sv
// simd_issue_sequencer: program sequencer for the 4-stage SIMD pipeline.
// It walks the instruction buffer from address 0, issues one instruction per
// cycle into IF/ID, inserts NOP bubbles on stall, drains the pipeline after
// the last instruction and pulses done. It also keeps per-stage valid bits
// and a busy-cycle counter for trace logic.
module simd_issue_sequencer #(
    parameter int                 IMEM_DEPTH   = 64,
    parameter int                 INSTR_W      = 25,
    parameter int                 DRAIN_CYCLES = 3,
    parameter logic [INSTR_W-1:0] NOP_INSTR    = 25'h1800000,
    localparam int                AW           = $clog2(IMEM_DEPTH),
    localparam int                LW           = AW + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LW-1:0]      prog_len,
    input  logic               stall,
    input  logic               abort,
    output logic [AW-1:0]      instr_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [2:0]         stage_valid,
    output logic               busy,
    output logic               done,
    output logic [15:0]        cycle_cnt
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e               state_q;
    logic [AW-1:0]        pc_q;
    logic [LW-1:0]        len_q;
    logic [DW-1:0]        drain_cnt_q;
    logic [INSTR_W-1:0]   instr_out_q;
    logic                 instr_valid_q;
    logic [2:0]           stage_valid_q;
    logic                 done_q;
    logic [15:0]          cycle_cnt_q;

    logic                 busy_w;
    logic                 issue_d;
    logic                 last_issue_d;
    logic [INSTR_W-1:0]   instr_d;
    logic [LW-1:0]        len_d;

    // Next-cycle issue decision, the word that goes into IF/ID and the clamped length.
    always_comb begin
        busy_w       = (state_q == S_FETCH) || (state_q == S_DRAIN);
        // abort outranks everything, so it suppresses the issue as well
        issue_d      = !abort && (state_q == S_FETCH) && !stall;
        last_issue_d = issue_d && ({1'b0, pc_q} == (len_q - LW'(1)));
        instr_d      = issue_d ? instr_in : NOP_INSTR;
        len_d        = (prog_len > LW'(IMEM_DEPTH)) ? LW'(IMEM_DEPTH) : prog_len;
    end

    // Sequencer FSM with registered datapath outputs, stage shifter and cycle counter.
    // NOTE: state is updated with non-blocking assignments only; mixing in blocking
    // assignments here would make later statements see half-updated state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            drain_cnt_q   <= '0;
            instr_out_q   <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            stage_valid_q <= '0;
            done_q        <= 1'b0;
            cycle_cnt_q   <= '0;
        end else begin
            instr_out_q   <= instr_d;
            instr_valid_q <= issue_d;
            stage_valid_q <= abort ? 3'b000 : {stage_valid_q[1:0], issue_d};
            done_q        <= 1'b0;

            if (busy_w && (cycle_cnt_q != 16'hFFFF)) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end

            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            cycle_cnt_q <= '0;
                            if (len_d != '0) begin
                                len_q   <= len_d;
                                pc_q    <= '0;
                                state_q <= S_FETCH;
                            end else begin
                                // empty program: straight to completion, no drain
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_FETCH: begin
                        if (issue_d) begin
                            // natural wrap at IMEM_DEPTH returns pc to 0 after a full buffer
                            pc_q <= pc_q + AW'(1);
                            if (last_issue_d) begin
                                drain_cnt_q <= DW'(DRAIN_CYCLES);
                                state_q     <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        drain_cnt_q <= drain_cnt_q - DW'(1);
                        if (drain_cnt_q == DW'(1)) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign instr_addr  = pc_q;
    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign stage_valid = stage_valid_q;
    assign busy        = busy_w;
    assign done        = done_q;
    assign cycle_cnt   = cycle_cnt_q;

endmodule
